rv32_e_div_unit: RTL and testbench

//  Iterative radix-2 divider for the execute stage. It services the RV32M ALU_DIV, ALU_DIVU,
//  ALU_REM and ALU_REMU control codes issued by decode. It stalls the pipeline via busy_o

---
 rtl/rv32_e_div_unit_pkg.sv | 40 ++++
 rtl/rv32_e_div_step.sv | 31 +++
 rtl/rv32_e_div_unit.sv | 184 ++++++++++++++++++
 tb/tb_rv32_e_div_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_e_div_unit_pkg.sv
// Shared definitions for the execute-stage divider: ALU control codes and divider FSM states.
package rv32_e_div_unit_pkg;

    localparam int ALU_CONTROL_WIDTH = 5;

    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SLL    = 5'd2;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SLT    = 5'd3;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SLTU   = 5'd4;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_XOR    = 5'd5;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OR     = 5'd8;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_AND    = 5'd9;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_MUL    = 5'd10;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_MULH   = 5'd11;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_MULHSU = 5'd12;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_MULHU  = 5'd13;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_DIV    = 5'd14;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_DIVU   = 5'd15;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_REM    = 5'd16;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_REMU   = 5'd17;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [ALU_CONTROL_WIDTH-1:0] code);
        logic hit;
        case (code)
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: hit = 1'b1;
            default:                              hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/rv32_e_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor, keep or restore.
module rv32_e_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic            dividend_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_bit_o
);

    // The incoming remainder is always below the divisor, so its top bit is never set.
    logic            unused_rem_msb_s;
    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   diff_s;

    assign unused_rem_msb_s = rem_i[XLEN];

    // Shifted partial is below twice the divisor, so diff_s[XLEN] is exactly the borrow.
    always_comb begin
        shifted_s = {rem_i[XLEN-1:0], dividend_bit_i};
        diff_s    = shifted_s - {1'b0, divisor_i};
        q_bit_o   = ~diff_s[XLEN];
        if (diff_s[XLEN]) begin
            rem_o = shifted_s;
        end else begin
            rem_o = diff_s;
        end
    end

endmodule

// File: rtl/rv32_e_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a fast path for
// divide-by-zero and signed overflow; stalls EX through busy_o while iterating.
module rv32_e_div_unit
    import rv32_e_div_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         start_i,
    input  logic [ALU_CONTROL_WIDTH-1:0] alu_control_i,
    input  logic [XLEN-1:0]              a_i,
    input  logic [XLEN-1:0]              b_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [XLEN-1:0]              result_o
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
        if (neg) begin
            return ~v + ONE;
        end else begin
            return v;
        end
    endfunction

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;

    logic            signed_op_s, rem_op_s, a_neg_s, b_neg_s, b_zero_s, special_s;
    logic            accept_s, fast_s;
    logic [XLEN-1:0] special_res_s;
    logic [XLEN:0]   step_rem_s;
    logic            step_q_s;

    // work_q holds the dividend shifting out at the top and the quotient filling in at the bottom.
    rv32_e_div_step #(.XLEN(XLEN)) u_step (
        .rem_i          (rem_q),
        .dividend_bit_i (work_q[XLEN-1]),
        .divisor_i      (divisor_q),
        .rem_o          (step_rem_s),
        .q_bit_o        (step_q_s)
    );

    // Decode of the incoming request and its RISC-V special-case result.
    always_comb begin
        signed_op_s = (alu_control_i == ALU_DIV) || (alu_control_i == ALU_REM);
        rem_op_s    = (alu_control_i == ALU_REM) || (alu_control_i == ALU_REMU);
        a_neg_s     = signed_op_s && a_i[XLEN-1];
        b_neg_s     = signed_op_s && b_i[XLEN-1];
        b_zero_s    = (b_i == ZERO);
        special_s   = b_zero_s || (signed_op_s && (a_i == MIN_NEG) && (b_i == ONES));
        if (b_zero_s) begin
            special_res_s = rem_op_s ? a_i : ONES;
        end else begin
            special_res_s = rem_op_s ? ZERO : a_i;
        end
        fast_s   = FAST_SPECIAL && special_s;
        accept_s = start_i && is_div_op(alu_control_i) && !flush_i &&
                   ((state_q == DIV_IDLE) || (state_q == DIV_DONE));
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE, DIV_DONE: begin
                    if (accept_s) begin
                        state_d = fast_s ? DIV_DONE : DIV_CALC;
                    end else begin
                        state_d = DIV_IDLE;
                    end
                end
                DIV_CALC: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = DIV_DONE;
                    end else begin
                        state_d = DIV_CALC;
                    end
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    // Datapath next-state: operand capture on accept, one step per CALC cycle, sign fix-up at the end.
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        is_rem_d   = is_rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        if (accept_s) begin
            is_rem_d   = rem_op_s;
            neg_quot_d = (a_neg_s ^ b_neg_s) && !b_zero_s;
            neg_rem_d  = a_neg_s;
            work_d     = apply_sign(a_i, a_neg_s);
            divisor_d  = apply_sign(b_i, b_neg_s);
            rem_d      = {(XLEN+1){1'b0}};
            cnt_d      = CNT_LAST;
            if (fast_s) begin
                result_d = special_res_s;
            end else begin
                result_d = result_q;
            end
        end else if ((state_q == DIV_CALC) && !flush_i) begin
            rem_d  = step_rem_s;
            work_d = {work_q[XLEN-2:0], step_q_s};
            if (cnt_q == CNT_ZERO) begin
                cnt_d    = cnt_q;
                result_d = is_rem_q ? apply_sign(step_rem_s[XLEN-1:0], neg_rem_q)
                                    : apply_sign({work_q[XLEN-2:0], step_q_s}, neg_quot_q);
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= CNT_ZERO;
            rem_q      <= {(XLEN+1){1'b0}};
            work_q     <= ZERO;
            divisor_q  <= ZERO;
            result_q   <= ZERO;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
            is_rem_q   <= is_rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    // Outputs decode straight from registered state.
    always_comb begin
        busy_o   = (state_q == DIV_CALC);
        done_o   = (state_q == DIV_DONE);
        result_o = result_q;
    end

endmodule

// File: tb/tb_rv32_e_div_unit.sv
// Scoreboard bench for rv32_e_div_unit: directed latency/special/flush/reset scenarios plus random ops.
module tb_rv32_e_div_unit;
    import rv32_e_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  ctl = ALU_ADD;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_v;
    int          lat, bcyc;

    logic [31:0] edges [9] = '{32'h0, 32'h1, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE,
                               32'h80000000, 32'h7FFFFFFF, 32'h80000001, 32'h7};
    logic [4:0]  ops [4] = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    rv32_e_div_unit dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .start_i(start),
        .alu_control_i(ctl), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .result_o(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        logic ovf;
        sx = int'(x);
        sy = int'(y);
        ovf = (x == 32'h80000000) && (y == 32'hFFFFFFFF);
        case (c)
            ALU_DIVU: return (y == 32'd0) ? 32'hFFFFFFFF : x / y;
            ALU_REMU: return (y == 32'd0) ? x : x % y;
            ALU_DIV:  return (y == 32'd0) ? 32'hFFFFFFFF : (ovf ? 32'h80000000 : 32'(sx / sy));
            ALU_REM:  return (y == 32'd0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
            default:  return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
        logic sgn;
        sgn = (c == ALU_DIV) || (c == ALU_REM);
        return ((y == 32'd0) || (sgn && x == 32'h80000000 && y == 32'hFFFFFFFF)) ? 1 : 33;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for one cycle from a sample point; returns in the cycle after acceptance.
    task automatic issue(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y, input bit push);
        ctl = c; a = x; b = y; start = 1'b1;
        if (push) sb_q.push_back(ref_model(c, x, y));
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int l, output int bc);
        l = 1; bc = 0;
        while (done !== 1'b1 && l < 64) begin
            if (busy === 1'b1) bc++;
            step();
            l++;
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
        rst = 1'b0;
        step();
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_non_div();
        int seen = 0;
        ctl = ALU_ADD; a = 32'd100; b = 32'd7; start = 1'b1;
        repeat (4) begin step(); if (busy === 1'b1 || done === 1'b1) seen++; end
        start = 1'b0;
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL non_div_ignored: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_unsigned();
        issue(ALU_DIVU, 32'd100, 32'd7, 1'b1);
        wait_done(lat, bcyc);
        exp_v = sb_q.pop_front();
        n_vec++; if (result !== exp_v) begin n_err++; $display("FAIL divu_100_7: got %h want %h", result, exp_v); end
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL divu_latency: got %0d want 33", lat); end
        n_vec++; if (bcyc != 32) begin n_err++; $display("FAIL divu_busy_cycles: got %0d want 32", bcyc); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_in_done: got %b want 0", busy); end
        step();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b want 0", done); end
        issue(ALU_REMU, 32'd100, 32'd7, 1'b1);
        wait_done(lat, bcyc);
        exp_v = sb_q.pop_front();
        n_vec++; if (result !== exp_v) begin n_err++; $display("FAIL remu_100_7: got %h want %h", result, exp_v); end
        step();
    endtask

    task automatic test_signed();
        issue(ALU_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_done(lat, bcyc);
        exp_v = sb_q.pop_front();
        n_vec++; if (result !== exp_v || exp_v !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_m7_2: got %h want %h", result, exp_v); end
        step();
        issue(ALU_REM, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_done(lat, bcyc);
        exp_v = sb_q.pop_front();
        n_vec++; if (result !== exp_v) begin n_err++; $display("FAIL rem_m7_2: got %h want %h", result, exp_v); end
        step();
    endtask

    task automatic test_special();
        logic [4:0]  c [4] = '{ALU_DIV, ALU_REMU, ALU_DIV, ALU_REM};
        logic [31:0] x [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] y [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            issue(c[i], x[i], y[i], 1'b1);
            wait_done(lat, bcyc);
            exp_v = sb_q.pop_front();
            n_vec++; if (result !== exp_v) begin n_err++; $display("FAIL special_%0d_result: got %h want %h", i, result, exp_v); end
            n_vec++; if (lat != 1) begin n_err++; $display("FAIL special_%0d_latency: got %0d want 1", i, lat); end
            step();
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        int seen = 0;
        prev = result;
        issue(ALU_DIVU, 32'd1000, 32'd3, 1'b0);
        repeat (9) step();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_busy_before: got %b want 1", busy); end
        flush = 1'b1; start = 1'b1; ctl = ALU_DIVU; a = 32'd77; b = 32'd7;
        step();
        flush = 1'b0; start = 1'b0;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL flush_idle: got busy=%b done=%b want 0/0", busy, done); end
        repeat (40) begin step(); if (busy === 1'b1 || done === 1'b1) seen++; end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL flush_no_done: got %0d active cycles want 0", seen); end
        n_vec++; if (result !== prev) begin n_err++; $display("FAIL flush_result_held: got %h want %h", result, prev); end
        issue(ALU_DIVU, 32'd9, 32'd3, 1'b1);
        wait_done(lat, bcyc);
        exp_v = sb_q.pop_front();
        n_vec++; if (result !== exp_v || lat != 33) begin n_err++; $display("FAIL after_flush_divu: got %h lat %0d want %h lat 33", result, lat, exp_v); end
        step();
    endtask

    task automatic test_start_during_calc();
        issue(ALU_DIVU, 32'd100, 32'd7, 1'b1);
        repeat (4) step();
        ctl = ALU_DIV; a = 32'd50; b = 32'd5; start = 1'b1;
        repeat (5) step();
        start = 1'b0;
        wait_done(lat, bcyc);
        exp_v = sb_q.pop_front();
        n_vec++; if (result !== exp_v) begin n_err++; $display("FAIL busy_start_result: got %h want %h", result, exp_v); end
        n_vec++; if (lat + 9 != 33) begin n_err++; $display("FAIL busy_start_latency: got %0d want 33", lat + 9); end
        step();
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL busy_start_dropped: got busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_back_to_back();
        issue(ALU_DIVU, 32'd1000, 32'd10, 1'b1);
        wait_done(lat, bcyc);
        exp_v = sb_q.pop_front();
        n_vec++; if (result !== exp_v) begin n_err++; $display("FAIL b2b_first: got %h want %h", result, exp_v); end
        issue(ALU_REM, 32'hFFFFFF9C, 32'd7, 1'b1);
        wait_done(lat, bcyc);
        exp_v = sb_q.pop_front();
        n_vec++; if (result !== exp_v || lat != 33) begin n_err++; $display("FAIL b2b_second: got %h lat %0d want %h lat 33", result, lat, exp_v); end
        issue(ALU_DIVU, 32'd1, 32'd0, 1'b1);
        wait_done(lat, bcyc);
        exp_v = sb_q.pop_front();
        n_vec++; if (result !== exp_v || lat != 1) begin n_err++; $display("FAIL b2b_special: got %h lat %0d want %h lat 1", result, lat, exp_v); end
        step();
    endtask

    task automatic test_async_reset();
        int seen = 0;
        issue(ALU_DIVU, 32'd12345, 32'd6, 1'b0);
        repeat (4) step();
        rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin n_err++; $display("FAIL async_reset: got busy=%b done=%b result=%h want 0/0/0", busy, done, result); end
        step(); step();
        rst = 1'b0;
        repeat (40) begin step(); if (busy === 1'b1 || done === 1'b1) seen++; end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL async_reset_no_done: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_random();
        logic [4:0]  c;
        logic [31:0] x, y;
        int          el;
        for (int i = 0; i < 1000; i++) begin
            c = ops[$urandom_range(0, 3)];
            x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 8)] : $urandom;
            if ($urandom_range(0, 3) == 0) y = edges[$urandom_range(0, 8)];
            else if ($urandom_range(0, 1) == 1) y = $urandom;
            else y = $urandom_range(1, 300);
            el = ref_latency(c, x, y);
            issue(c, x, y, 1'b1);
            wait_done(lat, bcyc);
            exp_v = sb_q.pop_front();
            n_vec++; if (result !== exp_v) begin n_err++; $display("FAIL rand_%0d op=%0d a=%h b=%h: got %h want %h", i, c, x, y, result, exp_v); end
            n_vec++; if (lat != el) begin n_err++; $display("FAIL rand_%0d_latency: got %0d want %0d", i, lat, el); end
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        test_reset();
        test_non_div();
        test_unsigned();
        test_signed();
        test_special();
        test_flush();
        test_start_during_calc();
        test_back_to_back();
        test_async_reset();
        test_random();
        n_vec++; if (sb_q.size() != 0) begin n_err++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
